// File: rtl/res_collector_if.sv
// Result stream handshake between the BFM result output and the collector.
// master = producer (BFM side), slave = collector.
interface res_collector_if #(
    parameter int RES_WIDTH = 8
);
    logic [RES_WIDTH-1:0] res_i;
    logic                 res_valid_i;
    logic                 res_ready_o;

    modport master (output res_i, output res_valid_i, input  res_ready_o);
    modport slave  (input  res_i, input  res_valid_i, output res_ready_o);
endinterface

// File: rtl/res_collector.sv
// Packs batches of JOINT_N results into a buffer, stalls when full until released.
// Optional running checksum on sum_o when RES_COLLECTOR_CHECKSUM_EN is defined.
module res_collector #(
    parameter int RES_WIDTH = 8,
    parameter int JOINT_N   = 100,
    parameter int ADDR_W    = $clog2(JOINT_N)
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    res_collector_if.slave       bus,
    input  logic                 release_i,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic [RES_WIDTH-1:0] rd_data_o,
    output logic [ADDR_W:0]      count_o,
    output logic                 batch_done_o,
    output logic                 batch_toggle_o,
    output logic [15:0]          sum_o
);
    typedef enum logic {S_COLLECT, S_FULL} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_ready;
    logic [ADDR_W-1:0]    r_wr_ptr;
    logic [ADDR_W:0]      r_count;
    logic                 r_done;
    logic                 r_toggle;
    logic [RES_WIDTH-1:0] r_rd_data;
    logic [RES_WIDTH-1:0] r_buf [JOINT_N];

    logic w_accept;
    logic w_last;
    logic w_release;
    logic w_rd_in_range;

    assign w_accept      = bus.res_valid_i && r_ready;
    assign w_last        = w_accept && (r_wr_ptr == ADDR_W'(JOINT_N - 1));
    assign w_release     = (r_state == S_FULL) && release_i;
    assign w_rd_in_range = ({1'b0, rd_addr_i} < (ADDR_W+1)'(JOINT_N));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: if (w_last)    w_state_nxt = S_FULL;
            S_FULL:    if (release_i) w_state_nxt = S_COLLECT;
            default:                  w_state_nxt = S_COLLECT;
        endcase
    end

    // ready is registered from the next state so it never depends on res_valid_i
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= S_COLLECT;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_COLLECT);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) r_toggle <= ~r_toggle;
            if (w_accept) begin
                r_wr_ptr <= w_last ? '0 : r_wr_ptr + ADDR_W'(1);
                r_count  <= r_count + (ADDR_W+1)'(1);
            end else if (w_release) begin
                r_count  <= '0;
            end
        end
    end

    // Storage is not reset; the read is registered, so a same-address write returns old data
    always_ff @(posedge clk_i) begin
        if (w_accept) r_buf[r_wr_ptr] <= bus.res_i;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)          r_rd_data <= '0;
        else if (w_rd_in_range) r_rd_data <= r_buf[rd_addr_i];
        else                    r_rd_data <= '0;
    end

`ifdef RES_COLLECTOR_CHECKSUM_EN
    logic [15:0] r_sum;
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)      r_sum <= '0;
        else if (w_accept)  r_sum <= r_sum + 16'(bus.res_i);
        else if (w_release) r_sum <= '0;
    end
    assign sum_o = r_sum;
`else
    assign sum_o = '0;
`endif

    assign bus.res_ready_o = r_ready;
    assign rd_data_o       = r_rd_data;
    assign count_o         = r_count;
    assign batch_done_o    = r_done;
    assign batch_toggle_o  = r_toggle;
endmodule
